// File: rtl/sm_mult_arbiter_if.sv
// sm_mult_arbiter_if: bundles the two requester channels and the shared
// multiplier's start/done/operand/product signals.
//   req0/a0/b0, req1/a1/b1 : requester channels, held until the matching ack
//   ack0/ack1, prod, err   : result return, one-cycle ack per completed request
//   busy, gnt              : arbiter status
//   m_start/m_md/m_mr      : arbiter -> multiplier
//   m_done/m_prod          : multiplier -> arbiter
// Modport slave is the arbiter's view; master is the clients'/multiplier's view.
interface sm_mult_arbiter_if #(
   parameter int unsigned WIDTH = 4
);
   logic                 req0;
   logic [WIDTH-1:0]     a0;
   logic [WIDTH-1:0]     b0;
   logic                 req1;
   logic [WIDTH-1:0]     a1;
   logic [WIDTH-1:0]     b1;
   logic                 ack0;
   logic                 ack1;
   logic [2*WIDTH-1:0]   prod;
   logic                 err;
   logic                 busy;
   logic                 gnt;
   logic                 m_start;
   logic [WIDTH-1:0]     m_md;
   logic [WIDTH-1:0]     m_mr;
   logic                 m_done;
   logic [2*WIDTH-1:0]   m_prod;

   modport slave (
      input  req0, a0, b0, req1, a1, b1, m_done, m_prod,
      output ack0, ack1, prod, err, busy, gnt, m_start, m_md, m_mr
   );

   modport master (
      output req0, a0, b0, req1, a1, b1, m_done, m_prod,
      input  ack0, ack1, prod, err, busy, gnt, m_start, m_md, m_mr
   );
endinterface

// File: rtl/sm_mult_arbiter.sv
// sm_mult_arbiter: shares one sequential multiplier between two requesters.
// Round-robin grant, operand capture, one-cycle start pulse, done wait with a
// watchdog, and a one-cycle ack to the granted requester.
// Ports:
//   clk : clock, all state changes on posedge
//   rst : asynchronous active-high reset
//   bus : sm_mult_arbiter_if.slave (requesters, results, status, multiplier link)
module sm_mult_arbiter #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned TIMEOUT = 31
) (
   input logic             clk,
   input logic             rst,
   sm_mult_arbiter_if.slave bus
);
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} state_e;

   state_e             state_q;
   logic               last_q;
   logic               gnt_q;
   logic               ack0_q;
   logic               ack1_q;
   logic               start_q;
   logic               busy_q;
   logic               err_q;
   logic [WIDTH-1:0]   md_q;
   logic [WIDTH-1:0]   mr_q;
   logic [2*WIDTH-1:0] prod_q;
   logic [CntW-1:0]    cnt_q;
   logic               win;

   // Tie goes to the requester that was not served last.
   assign win = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

   // Outputs are registered alongside the state so they line up with it:
   // start only in LAUNCH, busy outside IDLE, ack only in RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         md_q    <= '0;
         mr_q    <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else begin
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         start_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.req0 || bus.req1) begin
                  state_q <= StLaunch;
                  gnt_q   <= win;
                  md_q    <= win ? bus.a1 : bus.a0;
                  mr_q    <= win ? bus.b1 : bus.b0;
                  cnt_q   <= '0;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            // m_done is deliberately ignored here: it may still be high from
            // the previous operation until the multiplier sees the new start.
            StLaunch: begin
               state_q <= StWait;
            end
            StWait: begin
               if (bus.m_done) begin
                  prod_q  <= bus.m_prod;
                  err_q   <= 1'b0;
                  state_q <= StResp;
                  ack0_q  <= ~gnt_q;
                  ack1_q  <= gnt_q;
               end else if (cnt_q == CntMax) begin
                  prod_q  <= '0;
                  err_q   <= 1'b1;
                  state_q <= StResp;
                  ack0_q  <= ~gnt_q;
                  ack1_q  <= gnt_q;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StResp: begin
               state_q <= StIdle;
               last_q  <= gnt_q;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.ack0    = ack0_q;
   assign bus.ack1    = ack1_q;
   assign bus.prod    = prod_q;
   assign bus.err     = err_q;
   assign bus.busy    = busy_q;
   assign bus.gnt     = gnt_q;
   assign bus.m_start = start_q;
   assign bus.m_md    = md_q;
   assign bus.m_mr    = mr_q;
endmodule

// File: tb/tb_sm_mult_arbiter.sv
// tb_sm_mult_arbiter: self-checking bench for sm_mult_arbiter with a
// behavioural multiplier model and a round-robin reference model.
module tb_sm_mult_arbiter;
   localparam int unsigned W  = 4;
   localparam int unsigned TO = 31;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   n_ack0;
   int   n_ack1;
   int   n_start;

   sm_mult_arbiter_if #(.WIDTH(W)) bus ();

   sm_mult_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier model: captures operands on start, raises done after
   // mult_lat cycles and holds it until the next start; never finishes when
   // mult_hang is set. inj_done lets the bench force a stray done.
   int             mult_lat;
   logic           mult_hang;
   logic           mdl_done;
   logic [2*W-1:0] mdl_prod;
   logic           mdl_run;
   int             mdl_cnt;
   logic [W-1:0]   op_a;
   logic [W-1:0]   op_b;
   logic           inj_done;
   logic [2*W-1:0] inj_prod;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mdl_done <= 1'b0;
         mdl_prod <= '0;
         mdl_run  <= 1'b0;
         mdl_cnt  <= 0;
      end else if (bus.m_start) begin
         mdl_done <= 1'b0;
         mdl_run  <= !mult_hang;
         mdl_cnt  <= mult_lat;
         op_a     <= bus.m_md;
         op_b     <= bus.m_mr;
      end else if (mdl_run) begin
         if (mdl_cnt <= 1) begin
            mdl_done <= 1'b1;
            mdl_prod <= {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
            mdl_run  <= 1'b0;
         end else begin
            mdl_cnt <= mdl_cnt - 1;
         end
      end
   end

   assign bus.m_done = mdl_done | inj_done;
   assign bus.m_prod = inj_done ? inj_prod : mdl_prod;

   always @(negedge clk) begin
      if (bus.ack0) n_ack0++;
      if (bus.ack1) n_ack1++;
      if (bus.m_start) n_start++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits (bounded) for an ack; reports who got it and what was returned.
   task automatic wait_ack(input int budget, output logic got, output logic id,
                           output logic [2*W-1:0] p, output logic e,
                           output logic both, output int cyc, output int dcyc);
      got = 1'b0; id = 1'b0; p = '0; e = 1'b0; both = 1'b0; cyc = 0; dcyc = -1;
      while (!got && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (bus.m_done && dcyc < 0) dcyc = cyc;
         if (bus.ack0 || bus.ack1) begin
            got  = 1'b1;
            id   = bus.ack1;
            p    = bus.prod;
            e    = bus.err;
            both = bus.ack0 && bus.ack1;
         end
      end
   endtask

   task automatic test_reset();
      logic [21:0] outs;
      outs = {bus.ack0, bus.ack1, bus.busy, bus.m_start, bus.gnt, bus.err,
              bus.m_md, bus.m_mr, bus.prod};
      n_checks++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.m_start !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_no_req: busy=%b m_start=%b expected 0 0", bus.busy, bus.m_start);
      end
   endtask

   task automatic test_single();
      logic got, id, e, both;
      logic [2*W-1:0] p;
      int cyc, dcyc, s0, k1;
      do_reset();
      mult_lat = 10;
      s0 = n_start;
      k1 = n_ack1;
      @(negedge clk);
      bus.req0 = 1'b1; bus.a0 = 4'd3; bus.b0 = 4'd5;
      @(negedge clk);
      n_checks++;
      if (bus.m_start !== 1'b1 || bus.m_md !== 4'd3 || bus.m_mr !== 4'd5) begin
         n_fail++;
         $display("FAIL t1_launch: start=%b md=%0d mr=%0d expected 1 3 5",
                  bus.m_start, bus.m_md, bus.m_mr);
      end
      wait_ack(60, got, id, p, e, both, cyc, dcyc);
      bus.req0 = 1'b0;
      n_checks++;
      if (!got || id !== 1'b0 || p !== 8'd15 || e !== 1'b0 || bus.gnt !== 1'b0) begin
         n_fail++;
         $display("FAIL t1_result: got=%b id=%b prod=%0d err=%b gnt=%b expected 1 0 15 0 0",
                  got, id, p, e, bus.gnt);
      end
      n_checks++;
      if (cyc !== dcyc + 1) begin
         n_fail++;
         $display("FAIL t1_ack_latency: ack at %0d expected %0d", cyc, dcyc + 1);
      end
      @(negedge clk);
      n_checks++;
      if (bus.ack0 !== 1'b0 || n_start - s0 !== 1 || n_ack1 !== k1) begin
         n_fail++;
         $display("FAIL t1_pulses: ack0=%b starts=%0d ack1s=%0d expected 0 1 0",
                  bus.ack0, n_start - s0, n_ack1 - k1);
      end
   endtask

   task automatic test_tie();
      logic got, id, e, both;
      logic [2*W-1:0] p;
      int cyc, dcyc;
      do_reset();
      mult_lat = 3;
      bus.req0 = 1'b1; bus.a0 = 4'd2; bus.b0 = 4'd7;
      bus.req1 = 1'b1; bus.a1 = 4'd4; bus.b1 = 4'd4;
      wait_ack(60, got, id, p, e, both, cyc, dcyc);
      if (got) begin if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0; end
      n_checks++;
      if (!got || id !== 1'b0 || p !== 8'd14 || both !== 1'b0) begin
         n_fail++;
         $display("FAIL t2_first: got=%b id=%b prod=%0d expected 1 0 14", got, id, p);
      end
      wait_ack(60, got, id, p, e, both, cyc, dcyc);
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      n_checks++;
      if (!got || id !== 1'b1 || p !== 8'd16 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL t2_second: got=%b id=%b prod=%0d err=%b expected 1 1 16 0",
                  got, id, p, e);
      end
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL t2_busy_drop: busy=%b expected 0", bus.busy);
      end
   endtask

   task automatic test_fairness();
      logic got, id, e, both, last;
      logic [2*W-1:0] p;
      logic [W-1:0] a [2];
      logic [W-1:0] b [2];
      int cyc, dcyc;
      do_reset();
      last = 1'b1;
      mult_lat = 2;
      for (int i = 0; i < 2; i++) begin
         a[i] = W'($urandom);
         b[i] = W'($urandom);
      end
      bus.a0 = a[0]; bus.b0 = b[0]; bus.a1 = a[1]; bus.b1 = b[1];
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         logic exp_id;
         logic [2*W-1:0] exp_p;
         exp_id = ~last;
         exp_p  = 8'(int'(a[exp_id]) * int'(b[exp_id]));
         wait_ack(60, got, id, p, e, both, cyc, dcyc);
         n_checks++;
         if (!got || id !== exp_id || p !== exp_p || both !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_grant%0d: got=%b id=%b prod=%0d expected id=%b prod=%0d",
                     k, got, id, p, exp_id, exp_p);
         end
         last = exp_id;
         if (k == 3) begin
            bus.req0 = 1'b0; bus.req1 = 1'b0;
         end else begin
            a[exp_id] = W'($urandom);
            b[exp_id] = W'($urandom);
            bus.a0 = a[0]; bus.b0 = b[0]; bus.a1 = a[1]; bus.b1 = b[1];
         end
      end
   endtask

   task automatic test_timeout();
      logic got, id, e, both;
      logic [2*W-1:0] p;
      int cyc, dcyc;
      do_reset();
      mult_hang = 1'b1;
      @(negedge clk);
      bus.req0 = 1'b1; bus.a0 = 4'd6; bus.b0 = 4'd7;
      wait_ack(80, got, id, p, e, both, cyc, dcyc);
      bus.req0 = 1'b0;
      n_checks++;
      if (!got || cyc !== TO + 3) begin
         n_fail++;
         $display("FAIL t4_timeout_latency: got=%b cycles=%0d expected %0d", got, cyc, TO + 3);
      end
      n_checks++;
      if (id !== 1'b0 || e !== 1'b1 || p !== '0) begin
         n_fail++;
         $display("FAIL t4_abort: id=%b err=%b prod=%0d expected 0 1 0", id, e, p);
      end
      mult_hang = 1'b0;
      mult_lat  = 3;
      @(negedge clk);
      bus.req0 = 1'b1; bus.a0 = 4'd9; bus.b0 = 4'd11;
      wait_ack(80, got, id, p, e, both, cyc, dcyc);
      bus.req0 = 1'b0;
      n_checks++;
      if (!got || id !== 1'b0 || e !== 1'b0 || p !== 8'd99) begin
         n_fail++;
         $display("FAIL t4_recover: got=%b id=%b err=%b prod=%0d expected 1 0 0 99",
                  got, id, e, p);
      end
   endtask

   task automatic test_max_operands();
      logic got, id, e, both;
      logic [2*W-1:0] p;
      int cyc, dcyc;
      mult_lat = 5;
      @(negedge clk);
      bus.req1 = 1'b1; bus.a1 = 4'd15; bus.b1 = 4'd15;
      wait_ack(60, got, id, p, e, both, cyc, dcyc);
      bus.req1 = 1'b0;
      n_checks++;
      if (!got || id !== 1'b1 || p !== 8'hE1 || e !== 1'b0) begin
         n_fail++;
         $display("FAIL t5_max: got=%b id=%b prod=%h err=%b expected 1 1 e1 0", got, id, p, e);
      end
   endtask

   task automatic test_async_reset();
      logic [21:0] outs;
      int k0;
      do_reset();
      mult_lat = 20;
      k0 = n_ack0;
      @(negedge clk);
      bus.req0 = 1'b1; bus.a0 = 4'd5; bus.b0 = 4'd9;
      repeat (5) @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b1 || bus.m_start !== 1'b0 || bus.m_md !== 4'd5) begin
         n_fail++;
         $display("FAIL t6_in_wait: busy=%b start=%b md=%0d expected 1 0 5",
                  bus.busy, bus.m_start, bus.m_md);
      end
      #2;
      rst = 1'b1;
      bus.req0 = 1'b0;
      #1;
      outs = {bus.ack0, bus.ack1, bus.busy, bus.m_start, bus.gnt, bus.err,
              bus.m_md, bus.m_mr, bus.prod};
      n_checks++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL t6_async_clear: got %h expected 0", outs);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      inj_prod = 8'h55;
      inj_done = 1'b1;
      repeat (3) @(negedge clk);
      inj_done = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.prod !== '0 || n_ack0 !== k0) begin
         n_fail++;
         $display("FAIL t6_late_done: busy=%b prod=%h acks=%0d expected 0 0 0",
                  bus.busy, bus.prod, n_ack0 - k0);
      end
   endtask

   task automatic test_random();
      logic got, id, e, both, last, hang;
      logic [2*W-1:0] p;
      logic [1:0] mask, pend;
      logic [W-1:0] a [2];
      logic [W-1:0] b [2];
      int cyc, dcyc;
      do_reset();
      last = 1'b1;
      for (int r = 0; r < 25; r++) begin
         mask = 2'($urandom_range(1, 3));
         hang = ($urandom_range(0, 7) == 0);
         mult_lat  = $urandom_range(1, 8);
         mult_hang = hang;
         for (int i = 0; i < 2; i++) begin
            a[i] = W'($urandom);
            b[i] = W'($urandom);
         end
         @(negedge clk);
         bus.a0 = a[0]; bus.b0 = b[0]; bus.a1 = a[1]; bus.b1 = b[1];
         bus.req0 = mask[0]; bus.req1 = mask[1];
         pend = mask;
         for (int n = 0; n < 2 && pend != 2'b00; n++) begin
            logic exp_id;
            logic [2*W-1:0] exp_p;
            exp_id = (pend == 2'b11) ? ~last : pend[1];
            exp_p  = hang ? '0 : 8'(int'(a[exp_id]) * int'(b[exp_id]));
            wait_ack(80, got, id, p, e, both, cyc, dcyc);
            n_checks++;
            if (!got || id !== exp_id || p !== exp_p || e !== hang || both !== 1'b0) begin
               n_fail++;
               $display("FAIL rand%0d_op%0d: got=%b id=%b prod=%0d err=%b expected id=%b prod=%0d err=%b",
                        r, n, got, id, p, e, exp_id, exp_p, hang);
            end
            if (!got) begin
               pend = 2'b00;
            end else begin
               pend[id] = 1'b0;
               if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
            end
            last = exp_id;
         end
         bus.req0 = 1'b0;
         bus.req1 = 1'b0;
         @(negedge clk);
         n_checks++;
         if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rand%0d_idle: busy=%b expected 0", r, bus.busy);
         end
      end
      mult_hang = 1'b0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      n_ack0 = 0; n_ack1 = 0; n_start = 0;
      rst = 1'b1;
      bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0;
      bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0;
      mult_lat = 4; mult_hang = 1'b0;
      inj_done = 1'b0; inj_prod = '0;
      #12;
      test_reset();
      test_single();
      test_tie();
      test_fairness();
      test_timeout();
      test_max_operands();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
